// File: rtl/line_batch_controller_if.sv
// Control/status bundle between the line sequencer and the batch controller.
interface line_batch_controller_if;
    logic       start_batch;
    logic [3:0] batch_size;
    logic       stop_req;
    logic       clear_fault;
    logic       llenando;
    logic       sellando;
    logic       productook;
    logic       startfill;
    logic       batch_done;
    logic       fault;
    logic [3:0] good_count;
    logic [1:0] reject_count;
    logic [2:0] state_indicator;

    modport master (
        output start_batch, batch_size, stop_req, clear_fault,
               llenando, sellando, productook,
        input  startfill, batch_done, fault, good_count, reject_count, state_indicator
    );

    modport slave (
        input  start_batch, batch_size, stop_req, clear_fault,
               llenando, sellando, productook,
        output startfill, batch_done, fault, good_count, reject_count, state_indicator
    );
endinterface

// File: rtl/line_batch_controller.sv
// Batch sequencer for a fill/seal/inspect line: fills a latched number of good
// products, retries rejects, and faults on stalls or repeated rejects.
module line_batch_controller #(
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned MAX_REJECT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    line_batch_controller_if.slave   bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_FILL = 3'd1,
        FILLING  = 3'd2,
        SEALING  = 3'd3,
        CHECK    = 3'd4,
        DONE     = 3'd5,
        FAULT    = 3'd6
    } state_t;

    state_t        state;
    logic [3:0]    size_q;
    logic [3:0]    good_q;
    logic [1:0]    rej_q;
    logic [TW-1:0] timer;
    logic          stop_q;
    logic          startfill_q;
    logic          done_q;
    logic          fault_q;

    logic       stop_c;
    logic       timer_hit_c;
    logic [3:0] good_inc_c;
    logic [1:0] rej_inc_c;
    logic       rej_limit_c;

    // Saturating increments and decision terms used by the state register.
    always_comb begin
        stop_c      = stop_q | bus.stop_req;
        timer_hit_c = (timer >= T_LAST);
        good_inc_c  = (good_q == 4'hF) ? good_q : good_q + 4'd1;
        rej_inc_c   = (rej_q == 2'd3) ? rej_q : rej_q + 2'd1;
        rej_limit_c = (32'(rej_inc_c) >= MAX_REJECT);
    end

    // State, counters and registered outputs; outputs are set on the edge that enters their state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            size_q      <= 4'd0;
            good_q      <= 4'd0;
            rej_q       <= 2'd0;
            timer       <= '0;
            stop_q      <= 1'b0;
            startfill_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            startfill_q <= 1'b0;
            done_q      <= 1'b0;
            if (bus.stop_req && (state inside {REQ_FILL, FILLING, SEALING, CHECK}))
                stop_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start_batch && (bus.batch_size != 4'd0)) begin
                        size_q      <= bus.batch_size;
                        good_q      <= 4'd0;
                        rej_q       <= 2'd0;
                        stop_q      <= 1'b0;
                        timer       <= '0;
                        state       <= REQ_FILL;
                        startfill_q <= 1'b1;
                    end
                end
                REQ_FILL: begin
                    timer <= '0;
                    state <= FILLING;
                end
                FILLING: begin
                    if (bus.sellando) begin
                        timer <= '0;
                        state <= SEALING;
                    end else if (timer_hit_c) begin
                        timer   <= T_MAX;
                        stop_q  <= 1'b0;
                        fault_q <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SEALING: begin
                    if (!bus.sellando && !bus.llenando) begin
                        state <= CHECK;
                    end else if (timer_hit_c) begin
                        timer   <= T_MAX;
                        stop_q  <= 1'b0;
                        fault_q <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CHECK: begin
                    if (bus.productook) begin
                        good_q <= good_inc_c;
                        rej_q  <= 2'd0;
                        if (good_inc_c == size_q) begin
                            stop_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else if (stop_c) begin
                            stop_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            startfill_q <= 1'b1;
                            state       <= REQ_FILL;
                        end
                    end else begin
                        rej_q <= rej_inc_c;
                        if (rej_limit_c) begin
                            stop_q  <= 1'b0;
                            fault_q <= 1'b1;
                            state   <= FAULT;
                        end else if (stop_c) begin
                            stop_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            startfill_q <= 1'b1;
                            state       <= REQ_FILL;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
                    if (bus.clear_fault) begin
                        fault_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    fault_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.startfill       = startfill_q;
    assign bus.batch_done      = done_q;
    assign bus.fault           = fault_q;
    assign bus.good_count      = good_q;
    assign bus.reject_count    = rej_q;
    assign bus.state_indicator = 3'(state);

endmodule

// File: tb/tb_line_batch_controller.sv
// Directed bench for line_batch_controller: nominal batch, rejects, timeout,
// stop handling and asynchronous reset.
module tb_line_batch_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    line_batch_controller_if bus ();

    line_batch_controller #(.TIMEOUT_CYC(200), .MAX_REJECT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the run ever wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_batch = 1'b0;
        bus.batch_size  = 4'd0;
        bus.stop_req    = 1'b0;
        bus.clear_fault = 1'b0;
        bus.llenando    = 1'b0;
        bus.sellando    = 1'b0;
        bus.productook  = 1'b0;
    endtask

    task automatic start(input logic [3:0] size);
        bus.batch_size  = size;
        bus.start_batch = 1'b1;
        tick();
        bus.start_batch = 1'b0;
    endtask

    // Waits (bounded) for a startfill pulse; reports whether it came.
    task automatic wait_startfill(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.startfill === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Plays one product from REQ_FILL through CHECK; returns states seen on the way.
    task automatic run_product(input bit ok, input bit stop_pulse,
                               output logic [2:0] st_fill, output logic [2:0] st_seal,
                               output logic [2:0] st_chk);
        bus.llenando = 1'b1;
        tick();
        st_fill = bus.state_indicator;
        if (stop_pulse) begin
            bus.stop_req = 1'b1;
            tick();
            bus.stop_req = 1'b0;
            repeat (3) tick();
        end else begin
            repeat (4) tick();
        end
        bus.llenando = 1'b0;
        bus.sellando = 1'b1;
        tick();
        st_seal = bus.state_indicator;
        repeat (3) tick();
        bus.sellando = 1'b0;
        tick();
        st_chk = bus.state_indicator;
        bus.productook = ok;
        tick();
        bus.productook = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        checks++; if (bus.state_indicator !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state_indicator); end
        checks++; if (bus.startfill !== 1'b0 || bus.batch_done !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", bus.startfill, bus.batch_done, bus.fault); end
        checks++; if (bus.good_count !== 4'd0 || bus.reject_count !== 2'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.good_count, bus.reject_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal_batch();
        bit seen;
        int pulses = 0;
        logic [2:0] sf, ss, sc;
        start(4'd3);
        bus.batch_size = 4'd1;
        for (int p = 0; p < 3; p++) begin
            wait_startfill(seen);
            checks++; if (seen !== 1'b1) begin errors++; $display("FAIL nom_startfill%0d got %b want 1", p, seen); end
            if (seen) pulses++;
            run_product(1'b1, 1'b0, sf, ss, sc);
            checks++; if ({sf, ss, sc} !== {3'd2, 3'd3, 3'd4}) begin errors++; $display("FAIL nom_path%0d got %0d,%0d,%0d want 2,3,4", p, sf, ss, sc); end
            checks++; if (bus.good_count !== 4'(p + 1)) begin errors++; $display("FAIL nom_good%0d got %0d want %0d", p, bus.good_count, p + 1); end
        end
        checks++; if (bus.state_indicator !== 3'd5 || bus.batch_done !== 1'b1) begin errors++; $display("FAIL nom_done got st=%0d done=%b want 5/1", bus.state_indicator, bus.batch_done); end
        tick();
        checks++; if (bus.state_indicator !== 3'd0 || bus.batch_done !== 1'b0) begin errors++; $display("FAIL nom_idle got st=%0d done=%b want 0/0", bus.state_indicator, bus.batch_done); end
        checks++; if (bus.good_count !== 4'd3) begin errors++; $display("FAIL nom_good_hold got %0d want 3", bus.good_count); end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL nom_pulses got %0d want 3", pulses); end
    endtask

    task automatic test_reject_retry();
        bit seen;
        int pulses = 0;
        logic [2:0] sf, ss, sc;
        logic [1:0] rej_seen [3];
        bit oks [3] = '{1'b0, 1'b1, 1'b1};
        start(4'd2);
        for (int p = 0; p < 3; p++) begin
            wait_startfill(seen);
            if (seen) pulses++;
            run_product(oks[p], 1'b0, sf, ss, sc);
            rej_seen[p] = bus.reject_count;
        end
        checks++; if (rej_seen[0] !== 2'd1 || rej_seen[1] !== 2'd0) begin errors++; $display("FAIL rej_count got %0d,%0d want 1,0", rej_seen[0], rej_seen[1]); end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL rej_pulses got %0d want 3", pulses); end
        checks++; if (bus.good_count !== 4'd2 || bus.batch_done !== 1'b1) begin errors++; $display("FAIL rej_done got good=%0d done=%b want 2/1", bus.good_count, bus.batch_done); end
        tick();
    endtask

    task automatic test_timeout();
        int k;
        start(4'd1);
        tick();
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (bus.state_indicator === 3'd6) begin
                k = i;
                break;
            end
        end
        checks++; if (k !== 200) begin errors++; $display("FAIL to_cycles got %0d want 200", k); end
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b want 1", bus.fault); end
        bus.batch_size  = 4'd2;
        bus.start_batch = 1'b1;
        bus.sellando    = 1'b1;
        tick();
        bus.start_batch = 1'b0;
        bus.sellando    = 1'b0;
        checks++; if (bus.state_indicator !== 3'd6) begin errors++; $display("FAIL to_hold got %0d want 6", bus.state_indicator); end
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        checks++; if (bus.state_indicator !== 3'd0 || bus.fault !== 1'b0) begin errors++; $display("FAIL to_clear got st=%0d fault=%b want 0/0", bus.state_indicator, bus.fault); end
    endtask

    task automatic test_reject_fault();
        bit seen;
        logic [2:0] sf, ss, sc;
        start(4'd5);
        for (int p = 0; p < 3; p++) begin
            wait_startfill(seen);
            run_product(1'b0, 1'b0, sf, ss, sc);
        end
        checks++; if (bus.state_indicator !== 3'd6 || bus.fault !== 1'b1) begin errors++; $display("FAIL rf_state got st=%0d fault=%b want 6/1", bus.state_indicator, bus.fault); end
        checks++; if (bus.reject_count !== 2'd3) begin errors++; $display("FAIL rf_count got %0d want 3", bus.reject_count); end
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        start(4'd5);
        checks++; if (bus.reject_count !== 2'd0) begin errors++; $display("FAIL rf_restart got %0d want 0", bus.reject_count); end
        tick();
        repeat (199) tick();
        checks++; if (bus.state_indicator !== 3'd2) begin errors++; $display("FAIL rf_prelimit got %0d want 2", bus.state_indicator); end
        bus.sellando = 1'b1;
        tick();
        checks++; if (bus.state_indicator !== 3'd3 || bus.fault !== 1'b0) begin errors++; $display("FAIL rf_exit_wins got st=%0d fault=%b want 3/0", bus.state_indicator, bus.fault); end
        bus.sellando = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stop();
        bit seen;
        logic [2:0] sf, ss, sc;
        start(4'd4);
        wait_startfill(seen);
        run_product(1'b1, 1'b0, sf, ss, sc);
        wait_startfill(seen);
        run_product(1'b1, 1'b1, sf, ss, sc);
        checks++; if (sf !== 3'd2 || ss !== 3'd3 || sc !== 3'd4) begin errors++; $display("FAIL stop_no_abort got %0d,%0d,%0d want 2,3,4", sf, ss, sc); end
        checks++; if (bus.state_indicator !== 3'd0 || bus.batch_done !== 1'b0) begin errors++; $display("FAIL stop_idle got st=%0d done=%b want 0/0", bus.state_indicator, bus.batch_done); end
        checks++; if (bus.good_count !== 4'd2) begin errors++; $display("FAIL stop_good got %0d want 2", bus.good_count); end
        start(4'd2);
        wait_startfill(seen);
        run_product(1'b1, 1'b0, sf, ss, sc);
        checks++; if (bus.state_indicator !== 3'd1) begin errors++; $display("FAIL stop_cleared got %0d want 1", bus.state_indicator); end
        wait_startfill(seen);
        run_product(1'b1, 1'b1, sf, ss, sc);
        checks++; if (bus.state_indicator !== 3'd5 || bus.batch_done !== 1'b1) begin errors++; $display("FAIL stop_last_done got st=%0d done=%b want 5/1", bus.state_indicator, bus.batch_done); end
        tick();
    endtask

    task automatic test_reset_midbatch();
        bit seen;
        logic [2:0] sf, ss, sc;
        start(4'd3);
        for (int p = 0; p < 2; p++) begin
            wait_startfill(seen);
            run_product(1'b1, 1'b0, sf, ss, sc);
        end
        wait_startfill(seen);
        bus.llenando = 1'b1;
        tick();
        bus.llenando = 1'b0;
        bus.sellando = 1'b1;
        tick();
        checks++; if (bus.state_indicator !== 3'd3 || bus.good_count !== 4'd2) begin errors++; $display("FAIL mid_setup got st=%0d good=%0d want 3/2", bus.state_indicator, bus.good_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state_indicator !== 3'd0 || bus.good_count !== 4'd0 || bus.reject_count !== 2'd0) begin errors++; $display("FAIL mid_async got st=%0d good=%0d rej=%0d want 0/0/0", bus.state_indicator, bus.good_count, bus.reject_count); end
        checks++; if (bus.startfill !== 1'b0 || bus.batch_done !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b%b want 000", bus.startfill, bus.batch_done, bus.fault); end
        bus.sellando    = 1'b0;
        bus.batch_size  = 4'd2;
        bus.start_batch = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.state_indicator !== 3'd0) begin errors++; $display("FAIL rel_no_early got %0d want 0", bus.state_indicator); end
        tick();
        bus.start_batch = 1'b0;
        checks++; if (bus.state_indicator !== 3'd1) begin errors++; $display("FAIL rel_first_edge got %0d want 1", bus.state_indicator); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.batch_size  = 4'd0;
        bus.start_batch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.state_indicator !== 3'd0 || bus.startfill !== 1'b0) begin errors++; $display("FAIL size0_%0d got st=%0d sf=%b want 0/0", i, bus.state_indicator, bus.startfill); end
        end
        bus.start_batch = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_nominal_batch();
        test_reject_retry();
        test_timeout();
        test_reject_fault();
        test_stop();
        test_reset_midbatch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
